adxl362_ascii_uart_feeder: RTL and testbench

- Consumes the two 16-character ASCII display lines from the ADXL362 readings-to-ASCII stage and serialises them into a byte stream for the UART TX FIFO.
- On each request strobe, both lines are snapshotted and sent as line1, CR, LF, line2, CR, LF: 36 bytes with trimming off.
- Sits between the ASCII conversion block and the UART transmitter or its FIFO, on the single system clock.

---
 rtl/adxl362_ascii_uart_feeder.sv | 183 ++++++++++++++++++
 tb/tb_adxl362_ascii_uart_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_ascii_uart_feeder.sv
// Serialises two snapshotted ASCII display lines as line1,CR,LF,line2,CR,LF into a byte stream.
// Optional ADXL362_ASCII_FEED_TRIM_SPACES_EN drops trailing spaces from each line.
module adxl362_ascii_uart_feeder #(
  parameter int PARM_LINE_CHARS = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [8*PARM_LINE_CHARS-1:0] i_line1,
  input  logic [8*PARM_LINE_CHARS-1:0] i_line2,
  input  logic                         i_go,
  input  logic                         i_tx_ready,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int LINE_W = 8 * PARM_LINE_CHARS;
  localparam int IDX_W  = $clog2(PARM_LINE_CHARS) + 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SEND_CHARS = 3'd1;
  localparam logic [2:0] ST_SEND_CR    = 3'd2;
  localparam logic [2:0] ST_SEND_LF    = 3'd3;
  localparam logic [2:0] ST_FINISH     = 3'd4;

  logic [2:0]        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic              sel_r;
  logic [LINE_W-1:0] snap1_r;
  logic [LINE_W-1:0] snap2_r;
  logic [IDX_W-1:0]  len1_r;
  logic [IDX_W-1:0]  len2_r;

  logic [2:0]        state_n_s;
  logic [IDX_W-1:0]  idx_n_s;
  logic              sel_n_s;
  logic [IDX_W-1:0]  len1_s;
  logic [IDX_W-1:0]  len2_s;
  logic [IDX_W-1:0]  cur_len_s;
  logic [LINE_W-1:0] line_src_s;
  logic [7:0]        data_n_s;
  logic              transfer_s;

  function automatic logic [7:0] get_char(input logic [LINE_W-1:0] line,
                                          input logic [IDX_W-1:0]  idx);
    logic [7:0] ch;
    ch = 8'h00;
    for (int k = 0; k < PARM_LINE_CHARS; k++) begin
      if (idx == IDX_W'(k)) begin
        ch = line[LINE_W-1-8*k -: 8];
      end
    end
    return ch;
  endfunction

`ifdef ADXL362_ASCII_FEED_TRIM_SPACES_EN
  // Number of characters up to and including the last non-space; zero for an all-space line.
  function automatic logic [IDX_W-1:0] line_len(input logic [LINE_W-1:0] line);
    logic [IDX_W-1:0] len;
    len = {IDX_W{1'b0}};
    for (int k = 0; k < PARM_LINE_CHARS; k++) begin
      if (line[LINE_W-1-8*k -: 8] != 8'h20) begin
        len = IDX_W'(k + 1);
      end
    end
    return len;
  endfunction

  // Per-line send length from the live inputs, captured at snapshot time.
  always_comb begin
    len1_s = line_len(i_line1);
    len2_s = line_len(i_line2);
  end
`else
  // Every character of each line is always sent.
  always_comb begin
    len1_s = IDX_W'(PARM_LINE_CHARS);
    len2_s = IDX_W'(PARM_LINE_CHARS);
  end
`endif

  // Next-state, next-index and next-byte decode driven by the valid/ready handshake.
  always_comb begin
    transfer_s = o_tx_valid & i_tx_ready;
    state_n_s  = state_r;
    idx_n_s    = idx_r;
    sel_n_s    = sel_r;
    cur_len_s  = sel_r ? len2_r : len1_r;
    case (state_r)
      ST_IDLE: begin
        if (i_go) begin
          idx_n_s   = {IDX_W{1'b0}};
          sel_n_s   = 1'b0;
          state_n_s = (len1_s == {IDX_W{1'b0}}) ? ST_SEND_CR : ST_SEND_CHARS;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SEND_CHARS: begin
        if (transfer_s) begin
          idx_n_s   = idx_r + IDX_W'(1);
          state_n_s = ((idx_r + IDX_W'(1)) >= cur_len_s) ? ST_SEND_CR : ST_SEND_CHARS;
        end else begin
          state_n_s = ST_SEND_CHARS;
        end
      end
      ST_SEND_CR: begin
        if (transfer_s) begin
          state_n_s = ST_SEND_LF;
        end else begin
          state_n_s = ST_SEND_CR;
        end
      end
      ST_SEND_LF: begin
        if (transfer_s && !sel_r) begin
          sel_n_s   = 1'b1;
          idx_n_s   = {IDX_W{1'b0}};
          state_n_s = (len2_r == {IDX_W{1'b0}}) ? ST_SEND_CR : ST_SEND_CHARS;
        end else if (transfer_s) begin
          state_n_s = ST_FINISH;
        end else begin
          state_n_s = ST_SEND_LF;
        end
      end
      ST_FINISH: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase

    // The first byte comes straight from the inputs being snapshotted on this edge.
    if (sel_n_s) begin
      line_src_s = snap2_r;
    end else if (state_r == ST_IDLE) begin
      line_src_s = i_line1;
    end else begin
      line_src_s = snap1_r;
    end

    case (state_n_s)
      ST_SEND_CHARS: data_n_s = get_char(line_src_s, idx_n_s);
      ST_SEND_CR:    data_n_s = 8'h0D;
      ST_SEND_LF:    data_n_s = 8'h0A;
      default:       data_n_s = 8'h00;
    endcase
  end

  // Control state, line snapshot and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      sel_r      <= 1'b0;
      snap1_r    <= {LINE_W{1'b0}};
      snap2_r    <= {LINE_W{1'b0}};
      len1_r     <= {IDX_W{1'b0}};
      len2_r     <= {IDX_W{1'b0}};
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && i_go) begin
        snap1_r <= i_line1;
        snap2_r <= i_line2;
        len1_r  <= len1_s;
        len2_r  <= len2_s;
      end
      state_r    <= state_n_s;
      idx_r      <= idx_n_s;
      sel_r      <= sel_n_s;
      o_tx_data  <= data_n_s;
      o_tx_valid <= (state_n_s == ST_SEND_CHARS) || (state_n_s == ST_SEND_CR) ||
                    (state_n_s == ST_SEND_LF);
      o_busy     <= (state_n_s != ST_IDLE);
      o_done     <= (state_n_s == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_adxl362_ascii_uart_feeder.sv
// Self-checking bench: a byte-queue model of the expected stream plus directed scenarios.
module tb_adxl362_ascii_uart_feeder;

  localparam int N = 16;
`ifdef ADXL362_ASCII_FEED_TRIM_SPACES_EN
  localparam int T1_L = 14;
  localparam int T6_TOTAL = 19;
`else
  localparam int T1_L = 16;
  localparam int T6_TOTAL = 36;
`endif
  localparam int T1_TOTAL = 2 * T1_L + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] l1, l2;
  logic         go, ready;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid, o_busy, o_done;

  adxl362_ascii_uart_feeder #(.PARM_LINE_CHARS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_line1(l1), .i_line2(l2), .i_go(go),
    .i_tx_ready(ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: 0 idle, 1 streaming queued bytes, 2 done cycle.
  int         phase = 0;
  logic [7:0] q[$];
  logic [7:0] acc_b[$];
  int         acc_c[$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  function automatic void push_line(input logic [127:0] l);
    int last;
    last = N;
`ifdef ADXL362_ASCII_FEED_TRIM_SPACES_EN
    last = 0;
    for (int k = 0; k < N; k++) if (l[127-8*k -: 8] != 8'h20) last = k + 1;
`endif
    for (int k = 0; k < last; k++) q.push_back(l[127-8*k -: 8]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endfunction

  // Single compare process, on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", {31'd0, o_tx_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_data", {24'd0, o_tx_data}, 32'd0);
      phase = 0;
      q.delete();
    end else begin
      chk("valid", {31'd0, o_tx_valid}, {31'd0, phase == 1});
      chk("busy", {31'd0, o_busy}, {31'd0, phase != 0});
      chk("done", {31'd0, o_done}, {31'd0, phase == 2});
      if (phase == 1 && q.size() > 0) chk("data", {24'd0, o_tx_data}, {24'd0, q[0]});
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_tx_valid && ready) begin
        acc_b.push_back(o_tx_data);
        acc_c.push_back(cyc);
      end
      case (phase)
        0: if (go) begin
          q.delete();
          push_line(l1);
          push_line(l2);
          phase = 1;
        end
        1: if (ready) begin
          void'(q.pop_front());
          if (q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int g;

  task automatic start();
    acc_b.delete();
    acc_c.delete();
    done_cnt = 0;
    go = 1'b1;
    g = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (phase != 0 && n < 200) begin
      tick();
      n++;
    end
    if (phase != 0) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  logic [127:0] a1, a2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a1 = "X:0123  Y:ABCD  ";
    a2 = "Z:0001  T:0200  ";
    rst = 1'b0; go = 1'b0; ready = 1'b1; l1 = a1; l2 = a2;
    #1 rst = 1'b1;
    #1;
    chk("reset_data", {24'd0, o_tx_data}, 32'd0);
    chk("reset_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    while (cyc < 10) tick();

    // Free-running transfer
    start();
    wait_idle("t1");
    chk("t1_b0", {24'd0, acc_b[0]}, 32'h58);
    chk("t1_b1", {24'd0, acc_b[1]}, 32'h3A);
    chk("t1_b2", {24'd0, acc_b[2]}, 32'h30);
    chk("t1_b3", {24'd0, acc_b[3]}, 32'h31);
    chk("t1_cr1", {24'd0, acc_b[T1_L]}, 32'h0D);
    chk("t1_lf1", {24'd0, acc_b[T1_L+1]}, 32'h0A);
    chk("t1_cr2", {24'd0, acc_b[2*T1_L+2]}, 32'h0D);
    chk("t1_lf2", {24'd0, acc_b[2*T1_L+3]}, 32'h0A);
    chk("t1_count", acc_b.size(), T1_TOTAL);
    chk("t1_first_cyc", acc_c[0], g + 1);
    chk("t1_last_cyc", acc_c[T1_TOTAL-1], g + T1_TOTAL);
    chk("t1_done_cyc", done_cyc, g + T1_TOTAL + 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_low_cyc", cyc, g + T1_TOTAL + 2);
    chk("t1_busy_low", {31'd0, o_busy}, 32'd0);

    // Backpressure: byte 4 (0x31) is held while ready is low
    repeat (3) tick();
    start();
    begin
      int n;
      n = 0;
      while (phase != 0 && n < 200) begin
        tick();
        n++;
        ready = !(cyc >= g + 4 && cyc <= g + 8);
        if (cyc == g + 6) begin
          chk("t2_hold_data", {24'd0, o_tx_data}, 32'h31);
          chk("t2_hold_valid", {31'd0, o_tx_valid}, 32'd1);
        end
      end
      ready = 1'b1;
      if (phase != 0) chk("t2_timeout", 32'd1, 32'd0);
    end
    chk("t2_count", acc_b.size(), T1_TOTAL);
    chk("t2_b3_cyc", acc_c[3], g + 9);
    chk("t2_done_cnt", done_cnt, 1);

    // Snapshot: line1 changes after byte 5
    repeat (3) tick();
    start();
    begin
      int n;
      n = 0;
      while (phase != 0 && n < 200) begin
        tick();
        n++;
        if (acc_b.size() == 5) l1 = "X______ Y______ ";
      end
      if (phase != 0) chk("t3_timeout", 32'd1, 32'd0);
    end
    for (int k = 5; k < T1_L; k++) chk("t3_line1", {24'd0, acc_b[k]}, {24'd0, a1[127-8*k -: 8]});
    chk("t3_count", acc_b.size(), T1_TOTAL);
    l1 = a1;

    // Ignored requests: mid-transfer and during the done cycle
    repeat (3) tick();
    start();
    begin
      int n;
      n = 0;
      while (phase != 0 && n < 200) begin
        tick();
        n++;
        go = (cyc == g + 20) || (phase == 2);
      end
      go = 1'b0;
      if (phase != 0) chk("t4_timeout", 32'd1, 32'd0);
    end
    repeat (5) tick();
    chk("t4_count", acc_b.size(), T1_TOTAL);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_idle", {31'd0, o_busy}, 32'd0);

    // Reset mid-transfer
    start();
    begin
      int n;
      n = 0;
      while (acc_b.size() < 10 && n < 50) begin
        tick();
        n++;
      end
    end
    rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_data", {24'd0, o_tx_data}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_post_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_post_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("t5_no_done", done_cnt, 0);
    start();
    wait_idle("t5b");
    chk("t5_restart_count", acc_b.size(), T1_TOTAL);
    chk("t5_restart_done", done_cnt, 1);

    // All-space second line; trailing spaces trimmed when the feature is built in
    repeat (3) tick();
    l1 = "X-0.123 Y 0.345 ";
    l2 = {16{8'h20}};
    start();
    wait_idle("t6");
    chk("t6_count", acc_b.size(), T6_TOTAL);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_b14", {24'd0, acc_b[14]}, 32'h35);
`ifdef ADXL362_ASCII_FEED_TRIM_SPACES_EN
    chk("t6_cr1", {24'd0, acc_b[15]}, 32'h0D);
    chk("t6_lf1", {24'd0, acc_b[16]}, 32'h0A);
    chk("t6_cr2", {24'd0, acc_b[17]}, 32'h0D);
    chk("t6_lf2", {24'd0, acc_b[18]}, 32'h0A);
`else
    chk("t6_b15", {24'd0, acc_b[15]}, 32'h20);
    chk("t6_cr1", {24'd0, acc_b[16]}, 32'h0D);
    chk("t6_b18", {24'd0, acc_b[18]}, 32'h20);
    chk("t6_lf2", {24'd0, acc_b[35]}, 32'h0A);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
